// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between
// fetch and data ports, round-robin grant, watchdog abort.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        pick_dm;
  logic        tmo_hit;
  logic [31:0] rd_val;

  // Next-state: arbitration in IDLE, wait/abort in BUSY, ack in RESP
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    pick_dm     = 1'b0;
    tmo_hit     = 1'b0;
    rd_val      = '0;
    unique case (state_q)
      IDLE: begin
        pick_dm = dm_req_i & (~if_req_i | ~last_gnt_q);
        if (if_req_i | dm_req_i) begin
          state_d     = BUSY;
          gnt_d       = pick_dm;
          last_gnt_d  = pick_dm;
          tmo_cnt_d   = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_dm & dm_we_i;
          mem_addr_d  = pick_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = pick_dm ? dm_wdata_i : '0;
        end
      end
      BUSY: begin
        tmo_hit = ~mem_ack_i & (tmo_cnt_q == TMO_LAST);
        rd_val  = tmo_hit ? '0 : mem_rdata_i;
        if (mem_ack_i | tmo_hit) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if_ack_d  = ~gnt_q;
          dm_ack_d  = gnt_q;
          err_d     = tmo_hit;
          if (!mem_we_q) begin
            if (gnt_q) dm_rdata_d = rd_val;
            else       if_rdata_d = rd_val;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b0;
      gnt_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign err_o       = err_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;
  logic        stall_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_rdata_o (if_rdata_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_ack_o   (dm_ack_o),
    .dm_rdata_o (dm_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o),
    .stall_o    (stall_o)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: one access in flight, counted waits
  bit          m_busy = 0;
  bit          m_resp = 0;
  int          m_wait = 0;
  bit          m_port = 0;
  bit          m_last = 0;
  bit          m_err = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_dm_rd = '0;
  logic        m_pick;
  logic        e_if_ack, e_dm_ack, e_stall;

  assign m_pick   = (if_req_i && dm_req_i) ? !m_last : dm_req_i;
  assign e_if_ack = m_resp && !m_port;
  assign e_dm_ack = m_resp && m_port;
  assign e_stall  = (if_req_i && !e_if_ack) || (dm_req_i && !e_dm_ack);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_resp <= 0; m_wait <= 0; m_port <= 0;
      m_last <= 0; m_err <= 0; m_we <= 0; m_addr <= '0;
      m_wdata <= '0; m_if_rd <= '0; m_dm_rd <= '0;
    end else if (m_resp) begin
      m_resp <= 0;
      m_err  <= 0;
    end else if (m_busy) begin
      if (mem_ack_i || (m_wait + 1 == TMO)) begin
        m_busy <= 0;
        m_resp <= 1;
        m_err  <= !mem_ack_i;
        if (!m_we) begin
          if (m_port) m_dm_rd <= mem_ack_i ? mem_rdata_i : 32'h0;
          else        m_if_rd <= mem_ack_i ? mem_rdata_i : 32'h0;
        end
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (if_req_i || dm_req_i) begin
      m_busy  <= 1;
      m_wait  <= 0;
      m_port  <= m_pick;
      m_last  <= m_pick;
      m_we    <= m_pick && dm_we_i;
      m_addr  <= m_pick ? dm_addr_i : if_addr_i;
      m_wdata <= m_pick ? dm_wdata_i : 32'h0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("mem_req", mem_req_o, m_busy);
      chk1("mem_we", mem_we_o, m_we);
      chk32("mem_addr", mem_addr_o, m_addr);
      chk32("mem_wdata", mem_wdata_o, m_wdata);
      chk1("if_ack", if_ack_o, e_if_ack);
      chk1("dm_ack", dm_ack_o, e_dm_ack);
      chk1("err", err_o, m_resp && m_err);
      chk32("if_rdata", if_rdata_o, m_if_rd);
      chk32("dm_rdata", dm_rdata_o, m_dm_rd);
      chk1("stall", stall_o, e_stall);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int ack_cyc[$];
  int ack_prt[$];
  int stall_n;
  bit pia, pda;

  initial begin
    // Reset state
    #12;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_if_ack", if_ack_o, 1'b0);
    chk1("rst_dm_ack", dm_ack_o, 1'b0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    chk32("rst_if_rdata", if_rdata_o, 32'h0);
    chk32("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk1("rst_err", err_o, 1'b0);
    nxt();
    rst_n = 1'b1;
    chk_en = 1'b1;
    nxt();

    // Fetch only, memory acks in first BUSY cycle
    stall_n = 0;
    if_req_i = 1; if_addr_i = 32'h10;
    @(negedge clk);
    stall_n += int'(stall_o);
    nxt();
    mem_ack_i = 1; mem_rdata_i = 32'h2002000A;
    @(negedge clk);
    stall_n += int'(stall_o);
    chk32("f_addr", mem_addr_o, 32'h10);
    chk1("f_we", mem_we_o, 1'b0);
    nxt();
    mem_ack_i = 0; mem_rdata_i = 32'h0;
    @(negedge clk);
    stall_n += int'(stall_o);
    chk1("f_ack", if_ack_o, 1'b1);
    chk32("f_rdata", if_rdata_o, 32'h2002000A);
    nxt();
    if_req_i = 0;
    @(negedge clk);
    stall_n += int'(stall_o);
    chk32("f_stall_cycles", stall_n, 2);
    nxt();

    // Data write, memory acks in the third BUSY cycle
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h40;
    dm_wdata_i = 32'hDEADBEEF; mem_rdata_i = 32'h99999999;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) mem_ack_i = 1;
      else        mem_ack_i = 0;
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        chk1("w_we", mem_we_o, 1'b1);
        chk32("w_wdata", mem_wdata_o, 32'hDEADBEEF);
      end
      if (c == 4) begin
        chk1("w_ack", dm_ack_o, 1'b1);
        chk32("w_rdata", dm_rdata_o, 32'h0);
      end
      nxt();
    end
    dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
    nxt();

    // Reset one cycle into BUSY
    if_req_i = 1; if_addr_i = 32'h20;
    nxt();
    @(negedge clk);
    chk1("r_busy", mem_req_o, 1'b1);
    rst_n = 0;
    #1;
    chk1("r_req_async", mem_req_o, 1'b0);
    nxt();
    @(negedge clk);
    chk1("r_no_ack", if_ack_o, 1'b0);
    nxt();
    rst_n = 1;
    nxt();
    mem_ack_i = 1; mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    chk1("r_regrant", mem_req_o, 1'b1);
    chk32("r_addr", mem_addr_o, 32'h20);
    nxt();
    mem_ack_i = 0;
    @(negedge clk);
    chk1("r_ack", if_ack_o, 1'b1);
    chk32("r_rdata", if_rdata_o, 32'h0BADF00D);
    nxt();
    if_req_i = 0;
    nxt();

    // Contention after reset, immediate memory acks
    if_req_i = 1; if_addr_i = 32'h100;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200;
    mem_ack_i = 1; mem_rdata_i = 32'h12345678;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if_ack_o) begin ack_cyc.push_back(c); ack_prt.push_back(0); end
      if (dm_ack_o) begin ack_cyc.push_back(c); ack_prt.push_back(1); end
      nxt();
    end
    if_req_i = 0; dm_req_i = 0; mem_ack_i = 0;
    chk32("c_n_acks", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk32("c_ack_cycle", ack_cyc[i], 2 + 3 * i);
        chk32("c_ack_port", ack_prt[i], (i % 2 == 0) ? 1 : 0);
      end
    end
    nxt();

    // Stray memory ack while idle
    mem_ack_i = 1; mem_rdata_i = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1("s_if_ack", if_ack_o, 1'b0);
      chk1("s_dm_ack", dm_ack_o, 1'b0);
      chk32("s_if_rdata", if_rdata_o, 32'h12345678);
      chk32("s_dm_rdata", dm_rdata_o, 32'h12345678);
      nxt();
    end
    mem_ack_i = 0;

    // Timeout on a data read
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h80;
    mem_rdata_i = 32'hCAFEF00D;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) dm_req_i = 0;
      @(negedge clk);
      chk1("t_req", mem_req_o, (c >= 1 && c <= 4));
      chk1("t_ack", dm_ack_o, (c == 5));
      chk1("t_err", err_o, (c == 5));
      if (c == 5) chk32("t_rdata", dm_rdata_o, 32'h0);
      nxt();
    end

    // Random traffic
    pia = 0; pda = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_req_i) begin
        if (pia && $urandom_range(0, 1) == 0) if_req_i = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (dm_req_i) begin
        if (pda && $urandom_range(0, 1) == 0) dm_req_i = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req_i = 1; dm_we_i = 1'($urandom_range(0, 1));
        dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      mem_ack_i = ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
      if (c % 731 == 400) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
      #1;
      pia = e_if_ack;
      pda = e_dm_ack;
      nxt();
    end
    if_req_i = 0; dm_req_i = 0; mem_ack_i = 0;
    repeat (8) nxt();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory between the CPU's instruction-fetch port and its data load/store port. A three-state FSM grants one requester at a time and resolves ties by round-robin. It latches the granted request, drives the memory handshake and returns a one-cycle acknowledge with read data. A watchdog counter aborts memory accesses that never complete. The block sits between the program counter / data-memory stage and a unified memory, and its stall output freezes the PC while any port is waiting.

## Interface
- `TIMEOUT`, default 255: number of BUSY cycles without `mem_ack_i` before an access is aborted. Legal range 1–255.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req_i` in 1: fetch read request. Held high until `if_ack_o`.
- `if_addr_i` in 32: fetch address. Stable while `if_req_i` is high.
- `if_ack_o` out 1: one-cycle completion pulse for fetch.
- `if_rdata_o` out 32: fetched word. Valid when `if_ack_o` is high.
- `dm_req_i` in 1: data request. Held high until `dm_ack_o`.
- `dm_we_i` in 1: data request is a write (1) or a read (0).
- `dm_addr_i` in 32: data address.
- `dm_wdata_i` in 32: data write value.
- `dm_ack_o` out 1: one-cycle completion pulse for data.
- `dm_rdata_o` out 32: loaded word. Valid when `dm_ack_o` is high and the request was a read.
- `mem_req_o` out 1: request to memory. High for the whole BUSY state.
- `mem_we_o` out 1: latched write enable.
- `mem_addr_o` out 32: latched address.
- `mem_wdata_o` out 32: latched write data.
- `mem_ack_i` in 1: memory completion. `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in 32: memory read data.
- `err_o` out 1: pulses together with the ack when an access timed out.
- `stall_o` out 1: combinational, equal to `(if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o)`.

## Operation
- States: IDLE, BUSY, RESP. Reset state is IDLE.
- Registers: `last_gnt` (0 = IF, 1 = DM), reset value 0, so DM wins the first tie. `gnt` selects the active port. The 8-bit `tmo_cnt` resets to 0.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If only one port requests, grant it.
  - If both request, grant the port opposite to `last_gnt`.
  - On a grant: latch addr, we and wdata into `mem_*_o`, set `gnt` and `last_gnt`, clear `tmo_cnt`, go to BUSY.
  - The fetch port always latches we = 0 and wdata = 0.
- BUSY:
  - `mem_req_o` = 1.
  - When `mem_ack_i` = 1, capture `mem_rdata_i` into the granted port's rdata register (reads only) and go to RESP.
  - Otherwise increment `tmo_cnt`. When `tmo_cnt` = `TIMEOUT-1` and `mem_ack_i` = 0, go to RESP with the error flag set. The rdata register is then loaded with 0 (reads only).
- RESP:
  - `mem_req_o` = 0.
  - The granted port's ack is 1 for exactly one cycle. `err_o` = 1 if the error flag is set.
  - Always go to IDLE next. A request that is still high during RESP is never re-granted.
- Writes leave `dm_rdata_o` unchanged. `if_rdata_o` and `dm_rdata_o` hold their last value between acks.
- A `mem_ack_i` seen in IDLE or RESP is ignored.
- Reset values: every output is 0, every latched `mem_*` register is 0, and both rdata registers are 0.

## Timing
- Minimum request-to-ack latency is 2 cycles:
  - req seen in IDLE at cycle n;
  - BUSY with `mem_ack_i` at cycle n+1;
  - ack at cycle n+2;
  - back in IDLE at cycle n+3.
- Minimum occupancy is 3 cycles per transaction. The most back-to-back grants possible is one every 3 cycles.
- `mem_req_o` rises one cycle after the grant decision. It drops in the cycle after `mem_ack_i` or after the timeout.
- A timed-out access acks TIMEOUT+1 cycles after the grant edge.
- Asserting `rst_n` low at any time forces IDLE and clears all outputs immediately (asynchronous), including `mem_req_o` in the middle of BUSY. The outstanding access is abandoned with no ack.
- Requesters must drop req in the cycle after their ack. A req held longer is treated as a new request in IDLE.

## Test plan
- Fetch only: `if_req_i` = 1 with addr 0x00000010, memory acks in the first BUSY cycle with 0x2002000A. Required: `mem_addr_o` = 0x10 and `mem_we_o` = 0; `if_ack_o` pulses 2 cycles after the req with `if_rdata_o` = 0x2002000A; `stall_o` is high for exactly 2 cycles.
- Data write: `dm_req_i` = 1, `dm_we_i` = 1, addr 0x40, wdata 0xDEADBEEF, memory acks after 3 BUSY cycles. Required: `mem_we_o` = 1 and `mem_wdata_o` = 0xDEADBEEF throughout BUSY; `dm_ack_o` pulses in cycle 5; `dm_rdata_o` is unchanged.
- Contention after reset: both ports hold req continuously and every access is acked immediately. Required grant order DM, IF, DM, IF, with one ack every 3 cycles and no port granted twice in a row.
- Timeout: `TIMEOUT` = 4, a data read is granted and `mem_ack_i` stays 0. Required: BUSY lasts 4 cycles, then `dm_ack_o` = 1 and `err_o` = 1 in the same cycle with `dm_rdata_o` = 0, then IDLE.
- Reset mid-access: `rst_n` is driven low 1 cycle into BUSY. Required: `mem_req_o` goes to 0 with no clock edge; no ack occurs; after release the state is IDLE and a pending fetch is granted normally.
- Stray ack: `mem_ack_i` pulses while in IDLE with no requests. Required: no ack output, the state stays IDLE, and both rdata registers are unchanged.
